// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and the
// checksum width. The optional trailer checksum is enabled by the
// PROG_LOADER_CHECKSUM_EN macro.
package program_loader_pkg;

  // Trailer checksum is a running XOR of instruction words.
  localparam int unsigned CHK_WIDTH = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_CHECK = ST_CHECK,
    S_RUN   = ST_RUN,
    S_ERR   = ST_ERR
  } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Host stream, instruction-RAM write port and CPU release signals of the
// program loader. The host/bench drives the master side, the loader the slave.
interface program_loader_if #(
  parameter int unsigned BIT_WIDTH  = 4,
  parameter int unsigned INST_WIDTH = 8
) ();

  logic                  start;
  logic [BIT_WIDTH:0]    prog_len;
  logic [INST_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [BIT_WIDTH-1:0]  mem_addr;
  logic [INST_WIDTH-1:0] mem_data;
  logic                  mem_we;
  logic                  cpu_rst;
  logic                  done;
  logic                  err;

  modport master (
    output start, prog_len, in_data, in_valid,
    input  in_ready, mem_addr, mem_data, mem_we, cpu_rst, done, err
  );

  modport slave (
    input  start, prog_len, in_data, in_valid,
    output in_ready, mem_addr, mem_data, mem_we, cpu_rst, done, err
  );

endinterface

// File: rtl/load_addr_counter.sv
// Write-address counter for the program loader. Counts accepted words and
// flags when the next increment reaches the latched program length.
module load_addr_counter #(
  parameter int unsigned BIT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 inc_i,
  input  logic [BIT_WIDTH:0]   len_i,
  output logic [BIT_WIDTH-1:0] addr_o,
  output logic                 tc_o
);

  // One extra bit so a full-depth program count does not wrap to zero.
  logic [BIT_WIDTH:0] count_q, count_d;

  // Next count: clear wins over increment.
  always_comb begin
    count_d = count_q;
    if (clr_i)      count_d = '0;
    else if (inc_i) count_d = count_q + 1'b1;
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign addr_o = count_q[BIT_WIDTH-1:0];
  assign tc_o   = ((count_q + 1'b1) == len_i);

endmodule

// File: rtl/program_loader.sv
// Program loader: streams host words into instruction RAM, holding the CPU
// in reset until the program is complete. Optional trailer checksum is
// enabled with the PROG_LOADER_CHECKSUM_EN macro (default: disabled).
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = 4,
  parameter int unsigned INST_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  program_loader_if.slave bus
);

  localparam logic [BIT_WIDTH:0] DEPTH = {1'b1, {BIT_WIDTH{1'b0}}};

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_e S_AFTER_LOAD = S_CHECK;
`else
  localparam state_e S_AFTER_LOAD = S_RUN;
`endif

  state_e                state_q, state_d;
  logic [BIT_WIDTH:0]    len_q, len_d;
  logic [BIT_WIDTH-1:0]  cnt_addr;
  logic                  cnt_clr, cnt_inc, cnt_tc;
  logic                  accept;
  logic                  in_ready_q, in_ready_d;
  logic                  run_q, run_d;
  logic                  mem_we_q;
  logic [BIT_WIDTH-1:0]  mem_addr_q;
  logic [INST_WIDTH-1:0] mem_data_q;

  // in_ready is a pure registered state decode, so the handshake never
  // depends combinationally on in_valid.
  assign accept = bus.in_valid & in_ready_q;
  assign len_d  = (bus.prog_len > DEPTH) ? DEPTH : bus.prog_len;

  load_addr_counter #(.BIT_WIDTH(BIT_WIDTH)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .len_i  (len_q),
    .addr_o (cnt_addr),
    .tc_o   (cnt_tc)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [CHK_WIDTH-1:0] chk_q;
  logic                 err_q;
`endif

  // Next-state logic and counter control.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          cnt_inc = 1'b1;
          if (cnt_tc) state_d = S_AFTER_LOAD;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) state_d = (bus.in_data == chk_q) ? S_RUN : S_ERR;
      end
`endif
      default: begin
        // IDLE, RUN and ERR all (re)start a load on start.
        if (bus.start) begin
          cnt_clr = 1'b1;
          state_d = (len_d == '0) ? S_AFTER_LOAD : S_LOAD;
        end
      end
    endcase
  end

  // Registered output decode of the next state.
  always_comb begin
    in_ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
    run_d      = (state_d == S_RUN);
  end

  // Output registers, write port pipeline and length latch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_ready_q <= 1'b0;
      run_q      <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      len_q      <= '0;
    end else begin
      in_ready_q <= in_ready_d;
      run_q      <= run_d;
      mem_we_q   <= cnt_inc;
      if (cnt_inc) begin
        mem_addr_q <= cnt_addr;
        mem_data_q <= bus.in_data;
      end
      if (cnt_clr) len_q <= len_d;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // Running XOR of loaded words and the registered error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      chk_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= (state_d == S_ERR);
      if (cnt_clr)      chk_q <= '0;
      else if (cnt_inc) chk_q <= chk_q ^ bus.in_data;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready = in_ready_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.cpu_rst  = run_q;
  assign bus.done     = run_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader. Directed cases plus randomized
// loads, compared against a transaction-level model of the host stream.
// Honours PROG_LOADER_CHECKSUM_EN to match the build of the design.
module tb_program_loader;

  localparam int BW    = 4;
  localparam int IW    = 8;
  localparam int DEPTH = 16;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  program_loader_if #(.BIT_WIDTH(BW), .INST_WIDTH(IW)) bus ();

  program_loader #(.BIT_WIDTH(BW), .INST_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int we_count = 0;
  logic [IW-1:0] words [DEPTH];

  always @(negedge clk) if (bus.mem_we === 1'b1) we_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] xor_of(input int n);
    logic [IW-1:0] x = '0;
    for (int i = 0; i < n; i++) x ^= words[i];
    return x;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, ".cpu_rst"},  bus.cpu_rst,  0);
    check({tag, ".done"},     bus.done,     0);
    check({tag, ".err"},      bus.err,      0);
    check({tag, ".in_ready"}, bus.in_ready, 0);
    check({tag, ".mem_we"},   bus.mem_we,   0);
    check({tag, ".mem_addr"}, bus.mem_addr, 0);
    check({tag, ".mem_data"}, bus.mem_data, 0);
  endtask

  // One complete load. The model: min(plen, DEPTH) words land at addresses
  // 0.. in order, each visible one cycle after its handshake; with the
  // checksum one extra trailer word follows. The CPU is released once the
  // final word is taken (and the trailer matches the XOR of the words).
  task automatic run_load(input int plen, input bit gapped, input int extra,
                          input logic [IW-1:0] trailer, input string tag);
    int L, need, n_acc, base, cyc_max;
    bit fin, ok, pend, valid;
    logic [BW-1:0] pa;
    logic [IW-1:0] pd, d;
    L    = (plen > DEPTH) ? DEPTH : plen;
    need = CHK_EN ? L + 1 : L;
    ok   = CHK_EN ? (trailer == xor_of(L)) : 1'b1;
    base = we_count;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.prog_len = 5'(plen);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.prog_len = 5'($urandom);
    fin   = (need == 0);
    pend  = 1'b0;
    n_acc = 0;
    pa    = '0;
    pd    = '0;
    cyc_max = 2 * need + extra + 3;
    for (int cyc = 0; cyc < cyc_max; cyc++) begin
      check({tag, ".mem_we"}, bus.mem_we, pend);
      if (pend) begin
        check({tag, ".mem_addr"}, bus.mem_addr, pa);
        check({tag, ".mem_data"}, bus.mem_data, pd);
      end
      check({tag, ".in_ready"}, bus.in_ready, !fin);
      check({tag, ".done"},     bus.done,     fin && ok);
      check({tag, ".cpu_rst"},  bus.cpu_rst,  fin && ok);
      check({tag, ".err"},      bus.err,      fin && !ok);
      valid = gapped ? cyc[0] : 1'b1;
      if (fin && extra == 0) valid = 1'b0;
      if (n_acc < L)                 d = words[n_acc];
      else if (n_acc == L && CHK_EN) d = trailer;
      else                           d = IW'($urandom);
      bus.in_valid = valid;
      bus.in_data  = d;
      pend = 1'b0;
      if (valid && !fin) begin
        if (n_acc < L) begin
          pend = 1'b1;
          pa   = n_acc[BW-1:0];
          pd   = words[n_acc];
        end
        n_acc++;
        if (n_acc == need) fin = 1'b1;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check({tag, ".we_pulses"}, we_count - base, L);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int plen, extra;
    bit gapped;
    logic [IW-1:0] tr;

    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.prog_len = '0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    // Three words, back to back.
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    run_load(3, 1'b0, 0, xor_of(3), "three");

    // Full depth with a 17th word offered.
    for (int i = 0; i < DEPTH; i++) words[i] = IW'($urandom);
    run_load(16, 1'b0, 2, xor_of(16), "full");

    // Gapped valid, two words.
    words[0] = 8'hA5; words[1] = 8'h5A;
    run_load(2, 1'b1, 0, xor_of(2), "gapped");

    // Reset after one of four words, with the second word in flight.
    for (int i = 0; i < 4; i++) words[i] = IW'($urandom);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.prog_len = 5'd4;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = words[0];
    @(negedge clk);
    check("rstmid.mem_we",   bus.mem_we,   1);
    check("rstmid.mem_data", bus.mem_data, words[0]);
    bus.in_data = words[1];
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rstmid");
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    run_load(4, 1'b0, 0, xor_of(4), "after_rst");

    // Zero-length program.
    run_load(0, 1'b0, 1, 8'h00, "len0");

`ifdef PROG_LOADER_CHECKSUM_EN
    words[0] = 8'h0F; words[1] = 8'hF0;
    run_load(2, 1'b0, 0, 8'hFF, "chk_ok");
    run_load(2, 1'b0, 0, 8'h00, "chk_bad");
    run_load(2, 1'b0, 0, 8'hFF, "chk_clear");
    run_load(0, 1'b0, 0, 8'h3C, "chk_len0_bad");
`endif

    // Randomized loads.
    for (int it = 0; it < 30; it++) begin
      plen   = $urandom_range(0, 20);
      gapped = 1'($urandom_range(0, 1));
      extra  = $urandom_range(0, 2);
      for (int i = 0; i < DEPTH; i++) words[i] = IW'($urandom);
      tr = ($urandom_range(0, 1) == 1) ? IW'($urandom)
                                       : xor_of((plen > DEPTH) ? DEPTH : plen);
      run_load(plen, gapped, extra, tr, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
